// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI receive path.
// Word width and synchroniser depth defaults live here so every SPI block agrees.
package spi_pkg;

    localparam int SPI_WORD_W      = 8;
    localparam int SPI_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'b00,
        RX_SHIFT = 2'b01
    } rx_state_t;

endpackage

// File: rtl/spi_sync.sv
// N-stage single-bit synchroniser with a programmable reset level.
// Latency STAGES clk cycles; no flow control.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ff <= {STAGES{RST_VAL}};
        else      ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// Mode-0 SPI receiver: oversamples sclk/cs/mosi and deserialises MSB-first words; SYNC_STAGES+1 clk from final sclk rise to dout_valid.
// Backpressure: one output register; a word completing while dout is still held (no dout_ready) is dropped with an overrun pulse.
module spi_slave_rx #(
    parameter int DATA_W      = spi_pkg::SPI_WORD_W,
    parameter int SYNC_STAGES = spi_pkg::SPI_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              overrun,
    output logic              frame_err
);

    import spi_pkg::*;

    localparam int               CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

    logic sclk_s, cs_s, mosi_s;
    logic sclk_d, sclk_rise;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(sclk), .q(sclk_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .d(cs), .q(cs_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(mosi), .q(mosi_s));

    assign sclk_rise = sclk_s & ~sclk_d;

    // The cs synchroniser resets to "deselected", so its output is only trusted
    // once real pin samples have flushed through; armed then waits for a genuine
    // cs-high so a frame already in flight at reset release is ignored.
    logic [SYNC_STAGES-1:0] warm;
    logic                   armed;

    rx_state_t         state, state_nxt;
    logic [DATA_W-1:0] shift_q, shift_nxt, word;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;
    logic              word_done, ferr_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RX_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            sclk_d  <= 1'b0;
            warm    <= '0;
            armed   <= 1'b0;
        end else begin
            state   <= state_nxt;
            shift_q <= shift_nxt;
            cnt_q   <= cnt_nxt;
            sclk_d  <= sclk_s;
            warm    <= {warm[SYNC_STAGES-2:0], 1'b1};
            armed   <= armed | (warm[SYNC_STAGES-1] & cs_s);
        end
    end

    always_comb begin
        state_nxt = state;
        shift_nxt = shift_q;
        cnt_nxt   = cnt_q;
        word_done = 1'b0;
        ferr_nxt  = 1'b0;
        word      = {shift_q[DATA_W-2:0], mosi_s};
        case (state)
            RX_IDLE: begin
                shift_nxt = '0;
                cnt_nxt   = '0;
                if (!cs_s && armed) state_nxt = RX_SHIFT;
            end
            RX_SHIFT: begin
                // cs deassertion takes priority over a coincident sclk edge
                if (cs_s) begin
                    ferr_nxt  = (cnt_q != '0);
                    state_nxt = RX_IDLE;
                    shift_nxt = '0;
                    cnt_nxt   = '0;
                end else if (sclk_rise) begin
                    shift_nxt = word;
                    if (cnt_q == LAST) begin
                        cnt_nxt   = '0;
                        word_done = 1'b1;
                    end else begin
                        cnt_nxt = cnt_q + 1'b1;
                    end
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            overrun   <= 1'b0;
            frame_err <= ferr_nxt;
            busy      <= ~cs_s;
            if (word_done) begin
                if (!dout_valid || dout_ready) begin
                    dout       <= word;
                    dout_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed and randomised frames against a byte-queue reference for spi_slave_rx.
module tb_spi_slave_rx;

    logic       clk = 1'b0;
    logic       rst, sclk, cs, mosi, dout_ready;
    logic [7:0] dout;
    logic       dout_valid, busy, overrun, frame_err;

    int checks = 0;
    int errors = 0;

    // event log written only by the monitor
    int         cyc = 0, vcnt = 0, vlow = 0, ocnt = 0, fcnt = 0;
    logic       vprev = 1'b0;
    logic [7:0] got[$];
    int         rise_cyc[$];
    logic [7:0] model[$];

    always #5 clk = ~clk;

    spi_slave_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .busy(busy), .overrun(overrun), .frame_err(frame_err)
    );

    always @(negedge clk) begin
        if (dout_valid && dout_ready) got.push_back(dout);
        if (dout_valid) vcnt++; else vlow++;
        if (dout_valid && !vprev) rise_cyc.push_back(cyc);
        if (overrun) ocnt++;
        if (frame_err) fcnt++;
        vprev = dout_valid;
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tickn(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one sclk period of 8 clk: 4 low (mosi set up), 4 high
    task automatic bit_out(input logic b);
        mosi = b;
        sclk = 1'b0;
        tickn(4);
        sclk = 1'b1;
        tickn(4);
    endtask

    task automatic rise_only(input logic b);
        mosi = b;
        sclk = 1'b0;
        tickn(4);
        sclk = 1'b1;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) bit_out(w[i]);
    endtask

    task automatic start_frame();
        sclk = 1'b0;
        cs   = 1'b0;
        tickn(2);
    endtask

    task automatic end_frame();
        sclk = 1'b0;
        cs   = 1'b1;
        tickn(6);
    endtask

    initial begin
        int         f0, o0, v0, l0, g0, n0, nw;
        logic [7:0] w;

        rst = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; dout_ready = 1'b0;
        tickn(3);
        check("rst_dout", 32'(dout), 0);
        check("rst_valid", 32'(dout_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        rst = 1'b1;
        tickn(6);

        // single word, latency and pulse width
        dout_ready = 1'b1;
        f0 = fcnt; o0 = ocnt;
        start_frame();
        w = 8'hAA;
        for (int i = 7; i >= 1; i--) bit_out(w[i]);
        rise_only(w[0]);
        tick(); check("lat_c1_valid", 32'(dout_valid), 0);
        tick(); check("lat_c2_valid", 32'(dout_valid), 0);
        tick(); check("lat_c3_valid", 32'(dout_valid), 1);
        check("lat_c3_dout", 32'(dout), 32'hAA);
        tick(); check("valid_one_cycle", 32'(dout_valid), 0);
        end_frame();
        check("aa_overrun", 32'(ocnt - o0), 0);
        check("aa_frame_err", 32'(fcnt - f0), 0);

        // back-to-back words in one cs window
        g0 = got.size(); n0 = rise_cyc.size();
        start_frame();
        send_word(8'h3C);
        send_word(8'hF0);
        end_frame();
        check("b2b_count", 32'(got.size() - g0), 2);
        if (got.size() - g0 == 2) begin
            check("b2b_w0", 32'(got[g0]), 32'h3C);
            check("b2b_w1", 32'(got[g0+1]), 32'hF0);
        end
        if (rise_cyc.size() - n0 == 2)
            check("b2b_spacing", 32'(rise_cyc[n0+1] - rise_cyc[n0]), 64);

        // overrun with consumer stalled
        dout_ready = 1'b0;
        o0 = ocnt; f0 = fcnt;
        start_frame();
        send_word(8'h11);
        send_word(8'h22);
        end_frame();
        check("ovr_dout", 32'(dout), 32'h11);
        check("ovr_valid", 32'(dout_valid), 1);
        check("ovr_pulses", 32'(ocnt - o0), 1);
        check("ovr_frame_err", 32'(fcnt - f0), 0);
        dout_ready = 1'b1;
        tickn(2);
        check("ovr_drain_valid", 32'(dout_valid), 0);
        check("ovr_drain_dout", 32'(dout), 32'h11);

        // truncated frame then a good one
        f0 = fcnt; v0 = vcnt;
        start_frame();
        for (int i = 0; i < 5; i++) bit_out(1'($urandom_range(0, 1)));
        end_frame();
        check("trunc_frame_err", 32'(fcnt - f0), 1);
        check("trunc_no_valid", 32'(vcnt - v0), 0);
        start_frame();
        send_word(8'h5A);
        end_frame();
        check("after_trunc_dout", 32'(dout), 32'h5A);
        check("after_trunc_got", 32'(got[$]), 32'h5A);

        // async reset mid-frame
        start_frame();
        for (int i = 0; i < 4; i++) bit_out(1'($urandom_range(0, 1)));
        rst = 1'b0;
        #1;
        check("mid_rst_dout", 32'(dout), 0);
        check("mid_rst_valid", 32'(dout_valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_overrun", 32'(overrun), 0);
        check("mid_rst_frame_err", 32'(frame_err), 0);
        tickn(2);
        rst = 1'b1;
        v0 = vcnt; f0 = fcnt;
        send_word(8'hE7);
        end_frame();
        check("post_rst_ignored", 32'(vcnt - v0), 0);
        check("post_rst_no_ferr", 32'(fcnt - f0), 0);
        start_frame();
        send_word(8'hC3);
        end_frame();
        check("post_rst_dout", 32'(dout), 32'hC3);
        check("post_rst_got", 32'(got[$]), 32'hC3);

        // final rise coincident with consumer accepting the old word
        dout_ready = 1'b0;
        start_frame();
        send_word(8'h77);
        l0 = vlow; o0 = ocnt; g0 = got.size();
        w = 8'h88;
        for (int i = 7; i >= 1; i--) bit_out(w[i]);
        rise_only(w[0]);
        tickn(2);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        check("coinc_dout", 32'(dout), 32'h88);
        check("coinc_valid", 32'(dout_valid), 1);
        tick();
        end_frame();
        check("coinc_valid_held", 32'(vlow - l0), 0);
        check("coinc_no_overrun", 32'(ocnt - o0), 0);
        dout_ready = 1'b1;
        tickn(2);
        check("coinc_drained", 32'(dout_valid), 0);
        check("coinc_got_cnt", 32'(got.size() - g0), 2);
        if (got.size() - g0 == 2) begin
            check("coinc_got0", 32'(got[g0]), 32'h77);
            check("coinc_got1", 32'(got[g0+1]), 32'h88);
        end

        // cs rise on the same cycle as the 8th sclk rise
        f0 = fcnt; v0 = vcnt;
        start_frame();
        for (int i = 0; i < 7; i++) bit_out(1'($urandom_range(0, 1)));
        mosi = 1'b1;
        sclk = 1'b0;
        tickn(4);
        sclk = 1'b1;
        cs   = 1'b1;
        tickn(6);
        sclk = 1'b0;
        tickn(4);
        check("cs_wins_frame_err", 32'(fcnt - f0), 1);
        check("cs_wins_no_valid", 32'(vcnt - v0), 0);

        // randomised multi-word frames against the byte queue
        g0 = got.size();
        model.delete();
        for (int f = 0; f < 6; f++) begin
            nw = $urandom_range(1, 3);
            start_frame();
            for (int k = 0; k < nw; k++) begin
                w = 8'($urandom);
                model.push_back(w);
                send_word(w);
            end
            end_frame();
        end
        check("rand_count", 32'(got.size() - g0), 32'(model.size()));
        if (got.size() - g0 == model.size())
            for (int i = 0; i < model.size(); i++)
                check($sformatf("rand_word%0d", i), 32'(got[g0+i]), 32'(model[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
